ip_tx_upper_arbiter: RTL and testbench
======================================

// Module: ip_tx_upper_arbiter
// PURPOSE
//  Packet-level arbiter between two upper-layer TX streams (src0 = UDP, src1 = ICMP) and the single
//  upper-layer AXIS input of the IP TX framer.
//  - Grants one source per packet and forwards it beat-for-beat through a 1-cycle register stage.
//  - Optionally stamps a running 16-bit IP identification into user[15:0].
//  - Keeps per-source packet counters.
// PARAMETERS
//  P_ARB_MODE   0      0 = round-robin per packet, 1 = fixed priority (src0 wins)
//  P_ID_INSERT  1      1 = overwrite user[15:0] with internal ID counter, 0 = pass source ID through
//  P_ID_INIT    16'd0  ID counter value after reset
// PORTS
//  i_clk            in   1   clock; every register on rising edge
//  i_rst            in   1   reset, synchronous, active-high
//  s0_axis_data     in   64  src0 (UDP) data; same 6 signals for s1_* (ICMP)
//  s0_axis_user     in   56  {len16,flags3,type8,offset13,id16}, stable over the packet
//  s0_axis_keep     in   8   byte enables, MSB-first; only meaningful on last beat
//  s0_axis_last     in   1   last beat of packet
//  s0_axis_valid    in   1   beat valid
//  s0_axis_ready    out  1   beat accepted when valid & ready
//  m_axis_data      out  64  to IP TX framer upper input
//  m_axis_user      out  56  forwarded user, ID field per P_ID_INSERT
//  m_axis_keep      out  8   forwarded keep
//  m_axis_last      out  1   forwarded last
//  m_axis_valid     out  1   forwarded valid
//  m_axis_ready     in   1   packet-start permission from framer; drops after last, rises when framer is idle
//  o_grant          out  2   one-hot current grant, 0 when idle
//  o_pkt_cnt0       out  16  packets forwarded from src0, wraps
//  o_pkt_cnt1       out  16  packets forwarded from src1, wraps
// BEHAVIOUR
//  Reset: all m_* = 0; s*_ready = 0; o_grant = 0; counters = 0; ID = P_ID_INIT; RR pointer = src0; state = IDLE.
//  FSM states: IDLE, FWD, HOLD.
//  - IDLE:
//    - If m_axis_ready = 1 and any sN_valid = 1, select a winner.
//    - Mode 0: the RR pointer source wins if it requests, else the other source.
//    - Mode 1: src0 wins whenever it requests.
//    - Register o_grant and go to FWD.
//  - FWD:
//    - sG_ready = 1 combinationally for the granted source G only; the other ready stays 0.
//    - Each accepted beat appears on m_* exactly 1 cycle later (m_valid = 1).
//    - Cycles with no accepted beat drive m_valid = 0; sources must not insert gaps inside a packet.
//    - The beat with sG_last accepted:
//      - Increment o_pkt_cntG.
//      - Increment ID (16-bit wrap, FFFF -> 0000).
//      - RR pointer = other source.
//      - Go to HOLD.
//  - HOLD:
//    - Lasts 1 cycle; o_grant = 0, all ready = 0.
//    - Lets the framer deassert m_axis_ready.
//    - Then return to IDLE. A new grant needs m_axis_ready = 1 again.
//  Output register contents:
//  - m_user is captured from the first beat of the packet.
//  - If P_ID_INSERT = 1, m_user[15:0] = current ID, constant for the whole packet.
//  Other rules:
//  - m_axis_ready is sampled only in IDLE; dropping it mid-packet does not stall forwarding.
//  - Latency: s beat to m beat = 1 cycle.
//  - Minimum inter-packet spacing at m: 2 cycles (HOLD + IDLE) plus framer ready delay.
//  - Single-beat packet (valid & last on first beat): FWD lasts 1 cycle, counters update normally.
//  - Both sources request in the same IDLE cycle: arbitration rule only; the loser's valid/data must be held.
//  - i_rst mid-packet: abort immediately.
//    - m_valid = 0 the next cycle; no last is emitted.
//    - Counters and ID reinitialise; the partial packet is discarded.
// TESTING
//  1 Reset, src0 sends 4 beats with user len=24, keep last=F0 -> m shows same 4 beats 1 cycle late, user[15:0]=0000, cnt0=1.
//  2 Both sources hold valid, mode 0, ready toggled per packet -> grants alternate src0, src1, src0, ...; IDs 0, 1, 2.
//  3 Mode 1, both requesting continuously for 3 packets -> all 3 granted to src0; cnt1 stays 0.
//  4 m_axis_ready = 0 while src1 valid -> no grant, s1_ready = 0, m_valid = 0; ready -> 1 gives a grant next cycle.
//  5 ID preset FFFF via P_ID_INIT, send 2 packets -> user[15:0] = FFFF then 0000.
//  6 Assert i_rst on beat 2 of 5 -> m_valid = 0 the next cycle, o_grant = 0, cnt0 = 0, next packet starts cleanly.

Source files
------------

// File: rtl/ip_tx_upper_arbiter.sv
// Packet-level arbiter between the UDP (src0) and ICMP (src1) upper TX streams
// feeding the IP TX framer; one registered forwarding stage, ID stamping, packet counters.
module ip_tx_upper_arbiter #(
   parameter int unsigned P_ARB_MODE  = 0,
   parameter int unsigned P_ID_INSERT = 1,
   parameter logic [15:0] P_ID_INIT   = 16'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [63:0] s0_axis_data,
   input  logic [55:0] s0_axis_user,
   input  logic [7:0]  s0_axis_keep,
   input  logic        s0_axis_last,
   input  logic        s0_axis_valid,
   output logic        s0_axis_ready,
   input  logic [63:0] s1_axis_data,
   input  logic [55:0] s1_axis_user,
   input  logic [7:0]  s1_axis_keep,
   input  logic        s1_axis_last,
   input  logic        s1_axis_valid,
   output logic        s1_axis_ready,
   output logic [63:0] m_axis_data,
   output logic [55:0] m_axis_user,
   output logic [7:0]  m_axis_keep,
   output logic        m_axis_last,
   output logic        m_axis_valid,
   input  logic        m_axis_ready,
   output logic [1:0]  o_grant,
   output logic [15:0] o_pkt_cnt0,
   output logic [15:0] o_pkt_cnt1
);

   localparam int unsigned DW = 64;
   localparam int unsigned UW = 56;
   localparam int unsigned KW = 8;
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {IDLE, FWD, HOLD} state_t;

   state_t          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            rr_q, rr_d;
   logic            first_q, first_d;
   logic [CW-1:0]   id_q, id_d;
   logic [CW-1:0]   cnt0_q, cnt0_d;
   logic [CW-1:0]   cnt1_q, cnt1_d;
   logic [DW-1:0]   m_data_q, m_data_d;
   logic [UW-1:0]   m_user_q, m_user_d;
   logic [KW-1:0]   m_keep_q, m_keep_d;
   logic            m_last_q, m_last_d;
   logic            m_valid_q, m_valid_d;

   logic            accept;
   logic            win1;
   logic [DW-1:0]   sel_data;
   logic [UW-1:0]   sel_user;
   logic [KW-1:0]   sel_keep;
   logic            sel_last;

   // Arbitration, beat forwarding and packet bookkeeping
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      first_d   = first_q;
      id_d      = id_q;
      cnt0_d    = cnt0_q;
      cnt1_d    = cnt1_q;
      m_data_d  = m_data_q;
      m_user_d  = m_user_q;
      m_keep_d  = m_keep_q;
      m_last_d  = 1'b0;
      m_valid_d = 1'b0;

      s0_axis_ready = (state_q == FWD) && grant_q[0];
      s1_axis_ready = (state_q == FWD) && grant_q[1];
      accept = (s0_axis_valid && s0_axis_ready) || (s1_axis_valid && s1_axis_ready);

      sel_data = grant_q[1] ? s1_axis_data : s0_axis_data;
      sel_user = grant_q[1] ? s1_axis_user : s0_axis_user;
      sel_keep = grant_q[1] ? s1_axis_keep : s0_axis_keep;
      sel_last = grant_q[1] ? s1_axis_last : s0_axis_last;

      // rr_q = 1 means src1 holds the round-robin pointer
      if (P_ARB_MODE != 0) win1 = !s0_axis_valid;
      else                 win1 = rr_q ? s1_axis_valid : !s0_axis_valid;

      case (state_q)
         IDLE: begin
            if (m_axis_ready && (s0_axis_valid || s1_axis_valid)) begin
               grant_d = win1 ? 2'b10 : 2'b01;
               first_d = 1'b1;
               state_d = FWD;
            end
         end
         FWD: begin
            if (accept) begin
               m_valid_d = 1'b1;
               m_data_d  = sel_data;
               m_keep_d  = sel_keep;
               m_last_d  = sel_last;
               first_d   = 1'b0;
               if (first_q) begin
                  if (P_ID_INSERT != 0) m_user_d = {sel_user[UW-1:CW], id_q};
                  else                  m_user_d = sel_user;
               end
               if (sel_last) begin
                  if (grant_q[1]) cnt1_d = cnt1_q + CW'(1);
                  else            cnt0_d = cnt0_q + CW'(1);
                  id_d    = id_q + CW'(1);
                  rr_d    = grant_q[0];
                  grant_d = 2'b00;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         rr_q      <= 1'b0;
         first_q   <= 1'b0;
         id_q      <= P_ID_INIT;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
         m_data_q  <= '0;
         m_user_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         first_q   <= first_d;
         id_q      <= id_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
         m_data_q  <= m_data_d;
         m_user_q  <= m_user_d;
         m_keep_q  <= m_keep_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign m_axis_data  = m_data_q;
   assign m_axis_user  = m_user_q;
   assign m_axis_keep  = m_keep_q;
   assign m_axis_last  = m_last_q;
   assign m_axis_valid = m_valid_q;
   assign o_grant      = grant_q;
   assign o_pkt_cnt0   = cnt0_q;
   assign o_pkt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_ip_tx_upper_arbiter.sv
// Bench for ip_tx_upper_arbiter: three instances (RR, fixed priority, ID preset FFFF)
// checked by a beat scoreboard plus per-scenario expectations.
module tb_ip_tx_upper_arbiter;

   localparam int unsigned ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [ND];
   logic [63:0] s_data  [ND][2];
   logic [55:0] s_user  [ND][2];
   logic [7:0]  s_keep  [ND][2];
   logic        s_last  [ND][2];
   logic        s_valid [ND][2];
   logic        s_ready [ND][2];
   logic [63:0] m_data  [ND];
   logic [55:0] m_user  [ND];
   logic [7:0]  m_keep  [ND];
   logic        m_last  [ND];
   logic        m_valid [ND];
   logic        m_ready [ND];
   logic [1:0]  grant   [ND];
   logic [15:0] cnt0    [ND];
   logic [15:0] cnt1    [ND];

   generate
      for (genvar g = 0; g < ND; g++) begin : g_dut
         ip_tx_upper_arbiter #(
            .P_ARB_MODE  ((g == 1) ? 1 : 0),
            .P_ID_INSERT (1),
            .P_ID_INIT   ((g == 2) ? 16'hFFFF : 16'h0000)
         ) u_dut (
            .i_clk         (clk),
            .i_rst         (rst[g]),
            .s0_axis_data  (s_data[g][0]),
            .s0_axis_user  (s_user[g][0]),
            .s0_axis_keep  (s_keep[g][0]),
            .s0_axis_last  (s_last[g][0]),
            .s0_axis_valid (s_valid[g][0]),
            .s0_axis_ready (s_ready[g][0]),
            .s1_axis_data  (s_data[g][1]),
            .s1_axis_user  (s_user[g][1]),
            .s1_axis_keep  (s_keep[g][1]),
            .s1_axis_last  (s_last[g][1]),
            .s1_axis_valid (s_valid[g][1]),
            .s1_axis_ready (s_ready[g][1]),
            .m_axis_data   (m_data[g]),
            .m_axis_user   (m_user[g]),
            .m_axis_keep   (m_keep[g]),
            .m_axis_last   (m_last[g]),
            .m_axis_valid  (m_valid[g]),
            .m_axis_ready  (m_ready[g]),
            .o_grant       (grant[g]),
            .o_pkt_cnt0    (cnt0[g]),
            .o_pkt_cnt1    (cnt1[g])
         );
      end
   endgenerate

   int n_checks = 0;
   int n_fail   = 0;

   logic [128:0] exp_q    [ND][$];
   int           grant_log[ND][$];
   logic [15:0]  id_log   [ND][$];
   logic [15:0]  init_id  [ND];
   logic [15:0]  exp_id   [ND];
   logic [15:0]  pkt_id   [ND];
   bit           in_pkt   [ND];
   bit           ready_req[ND];
   bit           toggle_en[ND];
   int           low_cnt  [ND];

   logic [128:0] mon_exp, mon_got;

   // Scoreboard: check m beats, then record beats accepted at the coming edge
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (m_valid[d] === 1'b1) begin
            n_checks++;
            mon_got = {m_data[d], m_user[d], m_keep[d], m_last[d]};
            if (exp_q[d].size() == 0) begin
               n_fail++;
               $display("FAIL beat_unexpected dut%0d: got %h, required no beat", d, mon_got);
            end else begin
               mon_exp = exp_q[d].pop_front();
               if (mon_got !== mon_exp) begin
                  n_fail++;
                  $display("FAIL beat dut%0d: got %h, required %h", d, mon_got, mon_exp);
               end
            end
         end
         if (rst[d] === 1'b1) begin
            exp_q[d].delete();
            exp_id[d] = init_id[d];
            in_pkt[d] = 1'b0;
         end else begin
            for (int s = 0; s < 2; s++) begin
               if (s_valid[d][s] === 1'b1 && s_ready[d][s] === 1'b1) begin
                  if (!in_pkt[d]) begin
                     pkt_id[d] = exp_id[d];
                     id_log[d].push_back(exp_id[d]);
                     in_pkt[d] = 1'b1;
                  end
                  exp_q[d].push_back({s_data[d][s], s_user[d][s][55:16], pkt_id[d],
                                      s_keep[d][s], s_last[d][s]});
                  if (s_last[d][s]) begin
                     in_pkt[d] = 1'b0;
                     exp_id[d] = exp_id[d] + 16'd1;
                     grant_log[d].push_back(s);
                  end
               end
            end
         end
      end
   end

   // Framer model: optionally drops ready for two cycles after each last
   initial begin
      for (int d = 0; d < ND; d++) begin
         m_ready[d] = 1'b0;
         low_cnt[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            if (toggle_en[d] && m_valid[d] === 1'b1 && m_last[d] === 1'b1) low_cnt[d] = 2;
            else if (low_cnt[d] > 0) low_cnt[d]--;
            m_ready[d] = ready_req[d] && (low_cnt[d] == 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_accept(input int d, input int s);
      int t = 0;
      @(negedge clk);
      while (s_ready[d][s] !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 200) begin
         n_fail++;
         $display("FAIL accept_timeout dut%0d src%0d: waited %0d cycles, required ready", d, s, t);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int d, input int s, input int nb, input logic [55:0] user,
                           input logic [7:0] kl, input logic [63:0] base);
      for (int b = 0; b < nb; b++) begin
         s_data[d][s]  = base + 64'(b);
         s_user[d][s]  = user;
         s_keep[d][s]  = (b == nb - 1) ? kl : 8'hFF;
         s_last[d][s]  = (b == nb - 1);
         s_valid[d][s] = 1'b1;
         wait_accept(d, s);
      end
      s_valid[d][s] = 1'b0;
      s_last[d][s]  = 1'b0;
   endtask

   task automatic reset_dut(input int d);
      @(posedge clk);
      #1 rst[d] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst[d] = 1'b0;
      grant_log[d].delete();
      id_log[d].delete();
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input int d, input logic [15:0] e0, input logic [15:0] e1);
      n_checks += 2;
      if (cnt0[d] !== e0) begin
         n_fail++;
         $display("FAIL cnt0 dut%0d: got %0d, required %0d", d, cnt0[d], e0);
      end
      if (cnt1[d] !== e1) begin
         n_fail++;
         $display("FAIL cnt1 dut%0d: got %0d, required %0d", d, cnt1[d], e1);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         n_checks++;
         if (m_valid[d] !== 1'b0 || grant[d] !== 2'b00 || s_ready[d][0] !== 1'b0 ||
             s_ready[d][1] !== 1'b0 || m_data[d] !== 64'd0 || m_user[d] !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got valid=%b grant=%b rdy=%b%b data=%h user=%h, required all 0",
                     d, m_valid[d], grant[d], s_ready[d][1], s_ready[d][0], m_data[d], m_user[d]);
         end
         check_cnt(d, 16'd0, 16'd0);
      end
      for (int d = 0; d < ND; d++) rst[d] = 1'b0;
   endtask

   task automatic test_single_src();
      logic [55:0] u;
      ready_req[0] = 1'b1;
      reset_dut(0);
      u = {16'd24, 3'b010, 8'd17, 13'd0, 16'hABCD};
      send_pkt(0, 0, 4, u, 8'hF0, 64'h1111_0000_0000_0000);
      drain(3);
      check_cnt(0, 16'd1, 16'd0);
      n_checks++;
      if (id_log[0].size() != 1 || id_log[0][0] !== 16'h0000) begin
         n_fail++;
         $display("FAIL single_id: got %0d ids (first %h), required 1 id 0000",
                  id_log[0].size(), (id_log[0].size() > 0) ? id_log[0][0] : 16'hxxxx);
      end
      n_checks++;
      if (exp_q[0].size() != 0) begin
         n_fail++;
         $display("FAIL single_drain: got %0d pending beats, required 0", exp_q[0].size());
      end
   endtask

   task automatic test_round_robin();
      int eg[4] = '{0, 1, 0, 1};
      toggle_en[0] = 1'b1;
      reset_dut(0);
      fork
         begin
            send_pkt(0, 0, 3, {16'd40, 40'h0}, 8'hFF, 64'hA000);
            send_pkt(0, 0, 2, {16'd16, 40'h0}, 8'hC0, 64'hA100);
         end
         begin
            send_pkt(0, 1, 2, {16'd12, 40'h1}, 8'hFE, 64'hB000);
            send_pkt(0, 1, 1, {16'd8,  40'h2}, 8'h80, 64'hB100);
         end
      join
      drain(4);
      n_checks++;
      if (grant_log[0].size() != 4) begin
         n_fail++;
         $display("FAIL rr_pkts: got %0d packets, required 4", grant_log[0].size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (grant_log[0][i] != eg[i] || id_log[0][i] !== 16'(i)) begin
               n_fail++;
               $display("FAIL rr_order pkt%0d: got src%0d id %h, required src%0d id %h",
                        i, grant_log[0][i], id_log[0][i], eg[i], 16'(i));
            end
         end
      end
      check_cnt(0, 16'd2, 16'd2);
      toggle_en[0] = 1'b0;
   endtask

   task automatic test_fixed_priority();
      ready_req[1] = 1'b1;
      toggle_en[1] = 1'b1;
      reset_dut(1);
      fork
         begin
            for (int p = 0; p < 3; p++) send_pkt(1, 0, 2, {16'd10, 40'h3}, 8'hF8, 64'hC000 + 64'(p * 16));
            check_cnt(1, 16'd3, 16'd0);
         end
         send_pkt(1, 1, 2, {16'd14, 40'h4}, 8'hFC, 64'hD000);
      join
      drain(4);
      n_checks++;
      if (grant_log[1].size() != 4 || grant_log[1][0] != 0 || grant_log[1][1] != 0 ||
          grant_log[1][2] != 0 || grant_log[1][3] != 1) begin
         n_fail++;
         $display("FAIL prio_order: got %0d packets %p, required 0,0,0,1", grant_log[1].size(), grant_log[1]);
      end
      check_cnt(1, 16'd3, 16'd1);
   endtask

   task automatic test_ready_gate();
      ready_req[0] = 1'b0;
      reset_dut(0);
      fork
         send_pkt(0, 1, 2, {16'd20, 40'h5}, 8'hF0, 64'hE000);
         begin
            repeat (5) begin
               @(negedge clk);
               #1;
               n_checks++;
               if (grant[0] !== 2'b00 || s_ready[0][1] !== 1'b0 || m_valid[0] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL gate_idle: got grant=%b s1_ready=%b m_valid=%b, required 0/0/0",
                           grant[0], s_ready[0][1], m_valid[0]);
               end
            end
            ready_req[0] = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            n_checks++;
            if (grant[0] !== 2'b10 || s_ready[0][1] !== 1'b1 || s_ready[0][0] !== 1'b0) begin
               n_fail++;
               $display("FAIL gate_grant: got grant=%b rdy1=%b rdy0=%b, required 10/1/0",
                        grant[0], s_ready[0][1], s_ready[0][0]);
            end
         end
      join
      drain(3);
      check_cnt(0, 16'd0, 16'd1);
   endtask

   task automatic test_id_wrap();
      ready_req[2] = 1'b1;
      reset_dut(2);
      send_pkt(2, 0, 2, {16'd16, 40'h6}, 8'hFF, 64'hF000);
      send_pkt(2, 0, 1, {16'd4,  40'h7}, 8'hF0, 64'hF100);
      drain(3);
      n_checks++;
      if (id_log[2].size() != 2 || id_log[2][0] !== 16'hFFFF || id_log[2][1] !== 16'h0000) begin
         n_fail++;
         $display("FAIL id_wrap: got %0d ids %p, required FFFF,0000", id_log[2].size(), id_log[2]);
      end
      check_cnt(2, 16'd2, 16'd0);
   endtask

   task automatic test_reset_mid();
      ready_req[0] = 1'b1;
      reset_dut(0);
      s_data[0][0]  = 64'h5000;
      s_user[0][0]  = {16'd40, 40'h8};
      s_keep[0][0]  = 8'hFF;
      s_last[0][0]  = 1'b0;
      s_valid[0][0] = 1'b1;
      wait_accept(0, 0);
      s_data[0][0] = 64'h5001;
      rst[0]       = 1'b1;
      @(posedge clk);
      #1;
      rst[0]        = 1'b0;
      s_valid[0][0] = 1'b0;
      n_checks++;
      if (m_valid[0] !== 1'b0 || grant[0] !== 2'b00 || m_last[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort: got m_valid=%b grant=%b m_last=%b, required 0/00/0",
                  m_valid[0], grant[0], m_last[0]);
      end
      check_cnt(0, 16'd0, 16'd0);
      grant_log[0].delete();
      id_log[0].delete();
      send_pkt(0, 0, 3, {16'd24, 40'h9}, 8'hE0, 64'h6000);
      drain(3);
      check_cnt(0, 16'd1, 16'd0);
      n_checks++;
      if (id_log[0].size() != 1 || id_log[0][0] !== 16'h0000) begin
         n_fail++;
         $display("FAIL abort_restart_id: got %0d ids %p, required one id 0000", id_log[0].size(), id_log[0]);
      end
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst[d]       = 1'b1;
         init_id[d]   = (d == 2) ? 16'hFFFF : 16'h0000;
         exp_id[d]    = init_id[d];
         in_pkt[d]    = 1'b0;
         ready_req[d] = 1'b0;
         toggle_en[d] = 1'b0;
         for (int s = 0; s < 2; s++) begin
            s_data[d][s]  = '0;
            s_user[d][s]  = '0;
            s_keep[d][s]  = '0;
            s_last[d][s]  = 1'b0;
            s_valid[d][s] = 1'b0;
         end
      end
      test_reset();
      test_single_src();
      test_round_robin();
      test_fixed_priority();
      test_ready_gate();
      test_id_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
